// File: rtl/exe_stage_if.sv
// EXE-stage bundle: ID/EXE operands and controls in, redirect/stall and EXE/MEM register out.
// The stage uses the slave modport; the surrounding pipeline uses master.
interface exe_stage_if #(parameter int XLEN = 32);
  logic            EXE_valid;
  logic [6:0]      EXE_opcode;
  logic [2:0]      EXE_funct3;
  logic [6:0]      EXE_funct7;
  logic [XLEN-1:0] EXE_pc;
  logic [XLEN-1:0] EXE_imm;
  logic [XLEN-1:0] EXE_rs1_data;
  logic [XLEN-1:0] EXE_rs2_data;
  logic [4:0]      EXE_rd_addr;
  logic            EXE_MemRead;
  logic            EXE_MemWrite;
  logic            EXE_MemtoReg;
  logic            EXE_RegWrite;
  logic            EXE_MEM_RegWrite;
  logic            wire_exe_stall;
  logic            wire_branch_taken;
  logic [XLEN-1:0] wire_branch_target;
  logic            MEM_rd_src;
  logic            MEM_MemRead;
  logic            MEM_MemWrite;
  logic            MEM_MemtoReg;
  logic            MEM_RegWrite;
  logic [XLEN-1:0] MEM_pc_to_reg;
  logic [XLEN-1:0] MEM_ALU_out;
  logic [XLEN-1:0] MEM_rs2_data;
  logic [4:0]      MEM_rd_addr;
  logic [2:0]      MEM_funct3;

  modport master (
    output EXE_valid, EXE_opcode, EXE_funct3, EXE_funct7, EXE_pc, EXE_imm,
           EXE_rs1_data, EXE_rs2_data, EXE_rd_addr, EXE_MemRead, EXE_MemWrite,
           EXE_MemtoReg, EXE_RegWrite, EXE_MEM_RegWrite,
    input  wire_exe_stall, wire_branch_taken, wire_branch_target,
           MEM_rd_src, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite,
           MEM_pc_to_reg, MEM_ALU_out, MEM_rs2_data, MEM_rd_addr, MEM_funct3
  );

  modport slave (
    input  EXE_valid, EXE_opcode, EXE_funct3, EXE_funct7, EXE_pc, EXE_imm,
           EXE_rs1_data, EXE_rs2_data, EXE_rd_addr, EXE_MemRead, EXE_MemWrite,
           EXE_MemtoReg, EXE_RegWrite, EXE_MEM_RegWrite,
    output wire_exe_stall, wire_branch_taken, wire_branch_target,
           MEM_rd_src, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite,
           MEM_pc_to_reg, MEM_ALU_out, MEM_rs2_data, MEM_rd_addr, MEM_funct3
  );
endinterface

// File: rtl/exe_stage.sv
// RV32IM execute stage: ALU, branch resolution and the EXE/MEM register.
// Define EXE_MULDIV_EN to build the iterative mul/div unit; otherwise M-ops yield 0 with no stall.
module exe_stage #(
  parameter int XLEN    = 32,
  parameter int MD_ITER = 32
) (
  input  logic     clk,
  input  logic     rst,
  exe_stage_if.slave io_bus
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;

  logic [XLEN-1:0] w_rs1, w_rs2, w_imm, w_pc, w_op_b, w_alu, w_sra, w_result, w_final, w_md_result;
  logic [2:0]      w_f3;
  logic [4:0]      w_shamt;
  logic            w_is_m, w_is_jal, w_is_jalr, w_cond, w_stall;

  assign w_rs1     = io_bus.EXE_rs1_data;
  assign w_rs2     = io_bus.EXE_rs2_data;
  assign w_imm     = io_bus.EXE_imm;
  assign w_pc      = io_bus.EXE_pc;
  assign w_f3      = io_bus.EXE_funct3;
  assign w_is_m    = (io_bus.EXE_opcode == OP_R) && (io_bus.EXE_funct7 == 7'b0000001);
  assign w_is_jal  = (io_bus.EXE_opcode == OP_JAL);
  assign w_is_jalr = (io_bus.EXE_opcode == OP_JLR);
  assign w_op_b    = (io_bus.EXE_opcode == OP_R) ? w_rs2 : w_imm;
  assign w_shamt   = w_op_b[4:0];
  assign w_sra     = $signed(w_rs1) >>> w_shamt;

  // funct7[5] picks SUB only for register ops; ADDI never subtracts
  always_comb begin
    w_alu = '0;
    case (w_f3)
      3'd0: w_alu = ((io_bus.EXE_opcode == OP_R) && io_bus.EXE_funct7[5]) ? w_rs1 - w_op_b : w_rs1 + w_op_b;
      3'd1: w_alu = w_rs1 << w_shamt;
      3'd2: w_alu = {{(XLEN-1){1'b0}}, $signed(w_rs1) < $signed(w_op_b)};
      3'd3: w_alu = {{(XLEN-1){1'b0}}, w_rs1 < w_op_b};
      3'd4: w_alu = w_rs1 ^ w_op_b;
      3'd5: w_alu = io_bus.EXE_funct7[5] ? w_sra : w_rs1 >> w_shamt;
      3'd6: w_alu = w_rs1 | w_op_b;
      default: w_alu = w_rs1 & w_op_b;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (io_bus.EXE_opcode)
      OP_R, OP_I:     w_result = w_alu;
      OP_LUI:         w_result = w_imm;
      OP_AUI:         w_result = w_pc + w_imm;
      OP_LD, OP_ST:   w_result = w_rs1 + w_imm;
      OP_JAL, OP_JLR: w_result = w_pc + XLEN'(4);
      default:        w_result = '0;
    endcase
  end

  assign w_final = w_is_m ? w_md_result : w_result;

  always_comb begin
    w_cond = 1'b0;
    case (w_f3)
      3'd0: w_cond = (w_rs1 == w_rs2);
      3'd1: w_cond = (w_rs1 != w_rs2);
      3'd4: w_cond = ($signed(w_rs1) < $signed(w_rs2));
      3'd5: w_cond = !($signed(w_rs1) < $signed(w_rs2));
      3'd6: w_cond = (w_rs1 < w_rs2);
      3'd7: w_cond = !(w_rs1 < w_rs2);
      default: w_cond = 1'b0;
    endcase
  end

  assign io_bus.wire_branch_taken  = io_bus.EXE_valid &
                                     (((io_bus.EXE_opcode == OP_BR) & w_cond) | w_is_jal | w_is_jalr);
  assign io_bus.wire_branch_target = w_is_jalr ? ((w_rs1 + w_imm) & ~XLEN'(1)) : (w_pc + w_imm);
  assign io_bus.wire_exe_stall     = w_stall;

`ifdef EXE_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_t;
  localparam logic [4:0] LAST_CNT = 5'(MD_ITER - 1);

  md_state_t         r_state, w_next;
  logic [4:0]        r_cnt;
  logic [2:0]        r_fn;
  logic              r_neg, r_neg_r, r_div0;
  logic [2*XLEN-1:0] r_acc, r_mcand, w_prod;
  logic [XLEN-1:0]   r_mplr, w_abs_a, w_abs_b, w_quo, w_rem;
  logic [XLEN:0]     w_diff;
  logic              w_issue, w_a_neg, w_b_neg;

  assign w_issue = (r_state == S_IDLE) && io_bus.EXE_valid && w_is_m;
  assign w_a_neg = ((w_f3 == 3'd1) || (w_f3 == 3'd2) || (w_f3 == 3'd4) || (w_f3 == 3'd6)) && w_rs1[XLEN-1];
  assign w_b_neg = ((w_f3 == 3'd1) || (w_f3 == 3'd4) || (w_f3 == 3'd6)) && w_rs2[XLEN-1];
  assign w_abs_a = w_a_neg ? -w_rs1 : w_rs1;
  assign w_abs_b = w_b_neg ? -w_rs2 : w_rs2;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: if (w_issue) begin w_stall = 1'b1; w_next = S_BUSY; end
      S_BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == LAST_CNT) w_next = S_DONE;
      end
      S_DONE: if (io_bus.EXE_MEM_RegWrite) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Restoring divide: acc holds {remainder, quotient/dividend}, compare on 33 bits
  assign w_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_mplr};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0; r_fn <= '0; r_neg <= 1'b0; r_neg_r <= 1'b0; r_div0 <= 1'b0;
      r_acc <= '0; r_mcand <= '0; r_mplr <= '0;
    end else if (w_issue) begin
      r_cnt   <= '0;
      r_fn    <= w_f3;
      r_neg   <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_div0  <= (w_rs2 == '0);
      r_acc   <= w_f3[2] ? {{XLEN{1'b0}}, w_abs_a} : '0;
      r_mcand <= {{XLEN{1'b0}}, w_abs_a};
      r_mplr  <= w_abs_b;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 5'd1;
      if (r_fn[2]) begin
        if (!w_diff[XLEN]) r_acc <= {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        else               r_acc <= {r_acc[2*XLEN-2:0], 1'b0};
      end else begin
        if (r_mplr[0]) r_acc <= r_acc + r_mcand;
        r_mcand <= r_mcand << 1;
        r_mplr  <= r_mplr >> 1;
      end
    end
  end

  // Sign fix-up; divide-by-zero overrides the quotient, remainder falls out naturally
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_md_result = '0;
    case (r_fn)
      3'd0:             w_md_result = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: w_md_result = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       w_md_result = r_div0 ? '1 : w_quo;
      default:          w_md_result = w_rem;
    endcase
  end
`else
  assign w_stall     = 1'b0;
  assign w_md_result = '0;
`endif

  logic            r_rd_src, r_mem_rd, r_mem_wr, r_mem2reg, r_reg_wr;
  logic [XLEN-1:0] r_pc4, r_alu_out, r_rs2;
  logic [4:0]      r_rd;
  logic [2:0]      r_f3;

  // Bubbles (invalid slot or own stall) clear the whole register so nothing leaks downstream
  always_ff @(posedge clk) begin
    if (rst || (io_bus.EXE_MEM_RegWrite && (!io_bus.EXE_valid || w_stall))) begin
      r_rd_src <= 1'b0; r_mem_rd <= 1'b0; r_mem_wr <= 1'b0; r_mem2reg <= 1'b0; r_reg_wr <= 1'b0;
      r_pc4 <= '0; r_alu_out <= '0; r_rs2 <= '0; r_rd <= '0; r_f3 <= '0;
    end else if (io_bus.EXE_MEM_RegWrite) begin
      r_rd_src  <= w_is_jal | w_is_jalr;
      r_mem_rd  <= io_bus.EXE_MemRead;
      r_mem_wr  <= io_bus.EXE_MemWrite;
      r_mem2reg <= io_bus.EXE_MemtoReg;
      r_reg_wr  <= io_bus.EXE_RegWrite;
      r_pc4     <= w_pc + XLEN'(4);
      r_alu_out <= w_final;
      r_rs2     <= w_rs2;
      r_rd      <= io_bus.EXE_rd_addr;
      r_f3      <= w_f3;
    end
  end

  assign io_bus.MEM_rd_src    = r_rd_src;
  assign io_bus.MEM_MemRead   = r_mem_rd;
  assign io_bus.MEM_MemWrite  = r_mem_wr;
  assign io_bus.MEM_MemtoReg  = r_mem2reg;
  assign io_bus.MEM_RegWrite  = r_reg_wr;
  assign io_bus.MEM_pc_to_reg = r_pc4;
  assign io_bus.MEM_ALU_out   = r_alu_out;
  assign io_bus.MEM_rs2_data  = r_rs2;
  assign io_bus.MEM_rd_addr   = r_rd;
  assign io_bus.MEM_funct3    = r_f3;
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage; M-op tests follow whether EXE_MULDIV_EN is defined.
module tb_exe_stage;
  logic clk, rst;
  int   n_chk = 0, n_pass = 0;

  exe_stage_if #(.XLEN(32)) bus ();
  exe_stage #(.XLEN(32), .MD_ITER(32)) dut (.clk(clk), .rst(rst), .io_bus(bus.slave));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [3:0] ctl);
    bus.EXE_valid = v; bus.EXE_opcode = opc; bus.EXE_funct3 = f3; bus.EXE_funct7 = f7;
    bus.EXE_pc = pc; bus.EXE_imm = imm; bus.EXE_rs1_data = a; bus.EXE_rs2_data = b; bus.EXE_rd_addr = rd;
    {bus.EXE_MemRead, bus.EXE_MemWrite, bus.EXE_MemtoReg, bus.EXE_RegWrite} = ctl;
  endtask

  task automatic test_reset;
    drive(1, 7'b0110011, 3'd0, 7'd0, 32'h10, 32'd0, 32'd1, 32'd2, 5'd3, 4'b0001);
    tick; tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'd0) $display("FAIL reset_alu got %h want 0", bus.MEM_ALU_out); else n_pass++;
    n_chk++; if (bus.MEM_RegWrite !== 1'b0) $display("FAIL reset_regwrite got %b want 0", bus.MEM_RegWrite); else n_pass++;
    n_chk++; if (bus.MEM_pc_to_reg !== 32'd0) $display("FAIL reset_pc4 got %h want 0", bus.MEM_pc_to_reg); else n_pass++;
    n_chk++; if (bus.wire_exe_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", bus.wire_exe_stall); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_alu;
    drive(1, 7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0, 32'h7FFFFFFF, 32'h1, 5'd5, 4'b0001); tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'h80000000) $display("FAIL add got %h want 80000000", bus.MEM_ALU_out); else n_pass++;
    n_chk++; if (bus.MEM_RegWrite !== 1'b1 || bus.MEM_rd_addr !== 5'd5) $display("FAIL add_ctl got %b/%0d want 1/5", bus.MEM_RegWrite, bus.MEM_rd_addr); else n_pass++;
    drive(1, 7'b0110011, 3'd5, 7'h20, 32'h0, 32'h0, 32'h80000000, 32'h4, 5'd6, 4'b0001); tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'hF8000000) $display("FAIL sra got %h want F8000000", bus.MEM_ALU_out); else n_pass++;
    drive(1, 7'b0010011, 3'd5, 7'h20, 32'h0, 32'h404, 32'h80000000, 32'h0, 5'd6, 4'b0001); tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'hF8000000) $display("FAIL srai got %h want F8000000", bus.MEM_ALU_out); else n_pass++;
    drive(1, 7'b0110011, 3'd5, 7'h00, 32'h0, 32'h0, 32'h80000000, 32'h4, 5'd6, 4'b0001); tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'h08000000) $display("FAIL srl got %h want 08000000", bus.MEM_ALU_out); else n_pass++;
    drive(1, 7'b0110011, 3'd0, 7'h20, 32'h0, 32'h0, 32'd5, 32'd7, 5'd6, 4'b0001); tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'hFFFFFFFE) $display("FAIL sub got %h want FFFFFFFE", bus.MEM_ALU_out); else n_pass++;
    drive(1, 7'b0010011, 3'd0, 7'h20, 32'h0, 32'h400, 32'd1, 32'd0, 5'd6, 4'b0001); tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'h401) $display("FAIL addi got %h want 401", bus.MEM_ALU_out); else n_pass++;
    drive(1, 7'b0110011, 3'd2, 7'h00, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd0, 5'd6, 4'b0001); tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'd1) $display("FAIL slt got %h want 1", bus.MEM_ALU_out); else n_pass++;
    drive(1, 7'b0110011, 3'd3, 7'h00, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd0, 5'd6, 4'b0001); tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'd0) $display("FAIL sltu got %h want 0", bus.MEM_ALU_out); else n_pass++;
    drive(1, 7'b0010111, 3'd0, 7'h00, 32'h100, 32'h2000, 32'd0, 32'd0, 5'd7, 4'b0001); tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'h2100) $display("FAIL auipc got %h want 2100", bus.MEM_ALU_out); else n_pass++;
    drive(1, 7'b0110111, 3'd0, 7'h00, 32'h100, 32'h12345000, 32'd9, 32'd0, 5'd7, 4'b0001); tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'h12345000) $display("FAIL lui got %h want 12345000", bus.MEM_ALU_out); else n_pass++;
    drive(1, 7'b0100011, 3'd2, 7'h00, 32'h0, 32'd3, 32'h1001, 32'hDEADBEEF, 5'd0, 4'b0100); tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'h1004) $display("FAIL store_addr got %h want 1004", bus.MEM_ALU_out); else n_pass++;
    n_chk++; if (bus.MEM_rs2_data !== 32'hDEADBEEF || bus.MEM_funct3 !== 3'd2 || bus.MEM_MemWrite !== 1'b1)
      $display("FAIL store_pass got %h/%0d/%b want DEADBEEF/2/1", bus.MEM_rs2_data, bus.MEM_funct3, bus.MEM_MemWrite); else n_pass++;
  endtask

  task automatic test_branch;
    drive(1, 7'b1100011, 3'd4, 7'h00, 32'h40, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'd0, 5'd0, 4'b0000); #1;
    n_chk++; if (bus.wire_branch_taken !== 1'b1) $display("FAIL blt_taken got %b want 1", bus.wire_branch_taken); else n_pass++;
    n_chk++; if (bus.wire_branch_target !== 32'h38) $display("FAIL blt_target got %h want 38", bus.wire_branch_target); else n_pass++;
    bus.EXE_funct3 = 3'd6; #1;
    n_chk++; if (bus.wire_branch_taken !== 1'b0) $display("FAIL bltu_taken got %b want 0", bus.wire_branch_taken); else n_pass++;
    drive(0, 7'b1100011, 3'd0, 7'h00, 32'h40, 32'h8, 32'd3, 32'd3, 5'd0, 4'b0000); #1;
    n_chk++; if (bus.wire_branch_taken !== 1'b0) $display("FAIL beq_bubble got %b want 0", bus.wire_branch_taken); else n_pass++;
    drive(1, 7'b1100111, 3'd0, 7'h00, 32'h200, 32'd2, 32'h101, 32'd0, 5'd1, 4'b0001); #1;
    n_chk++; if (bus.wire_branch_taken !== 1'b1 || bus.wire_branch_target !== 32'h102)
      $display("FAIL jalr_redirect got %b/%h want 1/102", bus.wire_branch_taken, bus.wire_branch_target); else n_pass++;
    tick;
    n_chk++; if (bus.MEM_pc_to_reg !== 32'h204 || bus.MEM_rd_src !== 1'b1)
      $display("FAIL jalr_link got %h/%b want 204/1", bus.MEM_pc_to_reg, bus.MEM_rd_src); else n_pass++;
  endtask

  task automatic test_bubble;
    drive(0, 7'b0100011, 3'd0, 7'h00, 32'h0, 32'd4, 32'd8, 32'd1, 5'd4, 4'b0101); tick;
    n_chk++; if (bus.MEM_RegWrite !== 1'b0 || bus.MEM_MemWrite !== 1'b0)
      $display("FAIL bubble got rw=%b mw=%b want 0/0", bus.MEM_RegWrite, bus.MEM_MemWrite); else n_pass++;
  endtask

  task automatic test_downstream_hold;
    drive(1, 7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0, 32'd20, 32'd22, 5'd8, 4'b0001); tick;
    bus.EXE_MEM_RegWrite = 1'b0;
    drive(1, 7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0, 32'd1, 32'd2, 5'd9, 4'b0001); tick; tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'd42 || bus.MEM_rd_addr !== 5'd8)
      $display("FAIL hold_freeze got %h/%0d want 2A/8", bus.MEM_ALU_out, bus.MEM_rd_addr); else n_pass++;
    bus.EXE_MEM_RegWrite = 1'b1; tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'd3) $display("FAIL hold_release got %h want 3", bus.MEM_ALU_out); else n_pass++;
  endtask

`ifdef EXE_MULDIV_EN
  // Drives an M-op and waits (bounded) until stall drops; leaves the bench in the DONE cycle
  task automatic issue_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, output int cyc);
    drive(1, 7'b0110011, f3, 7'h01, 32'h0, 32'h0, a, b, 5'd10, 4'b0001);
    cyc = 0; #1;
    while (bus.wire_exe_stall === 1'b1 && cyc < 40) begin cyc++; tick; end
  endtask

  task automatic test_mul;
    int cyc;
    logic [2:0]  fn [4] = '{3'd1, 3'd3, 3'd0, 3'd2};
    logic [31:0] a  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF};
    logic [31:0] b  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'd2};
    logic [31:0] ex [4] = '{32'h0, 32'hFFFFFFFE, 32'hFFFFFFF1, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      issue_mop(fn[i], a[i], b[i], cyc);
      n_chk++; if (cyc != 33) $display("FAIL mul_stall_cycles[%0d] got %0d want 33", i, cyc); else n_pass++;
      n_chk++; if (bus.MEM_RegWrite !== 1'b0) $display("FAIL mul_bubble[%0d] got %b want 0", i, bus.MEM_RegWrite); else n_pass++;
      tick;
      n_chk++; if (bus.MEM_ALU_out !== ex[i] || bus.MEM_rd_addr !== 5'd10)
        $display("FAIL mul_result[%0d] got %h/%0d want %h/10", i, bus.MEM_ALU_out, bus.MEM_rd_addr, ex[i]); else n_pass++;
      drive(0, 7'b0, 3'd0, 7'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'b0000);
    end
  endtask

  task automatic test_div;
    int cyc;
    logic [2:0]  fn [5] = '{3'd4, 3'd6, 3'd5, 3'd4, 3'd6};
    logic [31:0] a  [5] = '{32'h80000000, 32'd7, 32'd5, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] b  [5] = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'd2, 32'd2};
    logic [31:0] ex [5] = '{32'h80000000, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      issue_mop(fn[i], a[i], b[i], cyc);
      n_chk++; if (cyc != 33) $display("FAIL div_stall_cycles[%0d] got %0d want 33", i, cyc); else n_pass++;
      tick;
      n_chk++; if (bus.MEM_ALU_out !== ex[i]) $display("FAIL div_result[%0d] got %h want %h", i, bus.MEM_ALU_out, ex[i]); else n_pass++;
      drive(0, 7'b0, 3'd0, 7'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'b0000);
    end
  endtask

  task automatic test_md_hold;
    int cyc;
    issue_mop(3'd5, 32'd100, 32'd7, cyc);
    bus.EXE_MEM_RegWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_chk++; if (bus.wire_exe_stall !== 1'b0 || bus.MEM_ALU_out !== 32'd0)
        $display("FAIL done_hold[%0d] got stall=%b alu=%h want 0/0", i, bus.wire_exe_stall, bus.MEM_ALU_out); else n_pass++;
    end
    bus.EXE_MEM_RegWrite = 1'b1; tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'd14) $display("FAIL done_release got %h want E", bus.MEM_ALU_out); else n_pass++;
    drive(0, 7'b0, 3'd0, 7'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'b0000);
  endtask

  task automatic test_reset_busy;
    drive(1, 7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0, 32'd2, 32'd3, 5'd3, 4'b0001); tick;
    bus.EXE_MEM_RegWrite = 1'b0;
    drive(1, 7'b0110011, 3'd4, 7'h01, 32'h0, 32'h0, 32'd50, 32'd5, 5'd10, 4'b0001);
    for (int i = 0; i < 11; i++) tick;
    n_chk++; if (bus.wire_exe_stall !== 1'b1 || bus.MEM_ALU_out !== 32'd5)
      $display("FAIL busy_mid got stall=%b alu=%h want 1/5", bus.wire_exe_stall, bus.MEM_ALU_out); else n_pass++;
    rst = 1'b1;
    drive(0, 7'b0, 3'd0, 7'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'b0000); tick;
    n_chk++; if (bus.wire_exe_stall !== 1'b0 || bus.MEM_ALU_out !== 32'd0 || bus.MEM_RegWrite !== 1'b0)
      $display("FAIL busy_reset got stall=%b alu=%h rw=%b want 0/0/0", bus.wire_exe_stall, bus.MEM_ALU_out, bus.MEM_RegWrite); else n_pass++;
    rst = 1'b0; bus.EXE_MEM_RegWrite = 1'b1;
    drive(1, 7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0, 32'd2, 32'd3, 5'd3, 4'b0001); #1;
    n_chk++; if (bus.wire_exe_stall !== 1'b0) $display("FAIL post_reset_stall got %b want 0", bus.wire_exe_stall); else n_pass++;
    tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'd5 || bus.MEM_RegWrite !== 1'b1)
      $display("FAIL post_reset_add got %h/%b want 5/1", bus.MEM_ALU_out, bus.MEM_RegWrite); else n_pass++;
  endtask
`else
  task automatic test_mop_passthrough;
    drive(1, 7'b0110011, 3'd0, 7'h01, 32'h0, 32'h0, 32'd3, 32'd5, 5'd9, 4'b0001); #1;
    n_chk++; if (bus.wire_exe_stall !== 1'b0) $display("FAIL mop_stall got %b want 0", bus.wire_exe_stall); else n_pass++;
    tick;
    n_chk++; if (bus.MEM_ALU_out !== 32'd0 || bus.MEM_RegWrite !== 1'b1 || bus.MEM_rd_addr !== 5'd9)
      $display("FAIL mop_pass got %h/%b/%0d want 0/1/9", bus.MEM_ALU_out, bus.MEM_RegWrite, bus.MEM_rd_addr); else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.EXE_MEM_RegWrite = 1'b1;
    drive(0, 7'b0, 3'd0, 7'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'b0000);
    test_reset;
    test_alu;
    test_branch;
    test_bubble;
    test_downstream_hold;
`ifdef EXE_MULDIV_EN
    test_mul;
    test_div;
    test_md_hold;
    test_reset_busy;
`else
    test_mop_passthrough;
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage RV32IM core. Sits between the ID/EXE register and the MEM stage, and computes ALU results, load/store addresses, branch/jump decisions and link values. Holds the EXE/MEM pipeline register (all `MEM_*` outputs). Contains an iterative multiply/divide unit that stalls the front of the pipeline while it works.

## Interface
Parameters
- `XLEN`, 32, datapath width; only 32 is supported.
- `MD_ITER`, 32, mul/div iteration count; must equal `XLEN`.

Ports

Clock and reset (already decided): one clock; reset is synchronous and active-high.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.

From ID/EXE:
- `EXE_valid` in 1 — the instruction in EXE is real (0 = bubble).
- `EXE_opcode` in 7, `EXE_funct3` in 3, `EXE_funct7` in 7 — decode fields.
- `EXE_pc` in 32, `EXE_imm` in 32 — PC and sign-extended immediate.
- `EXE_rs1_data` in 32, `EXE_rs2_data` in 32 — operands, already forwarded.
- `EXE_rd_addr` in 5 — destination register.
- `EXE_MemRead`, `EXE_MemWrite`, `EXE_MemtoReg`, `EXE_RegWrite` in 1 each — control bits from ID.

Pipeline control:
- `EXE_MEM_RegWrite` in 1 — advance enable for the EXE/MEM register (0 = downstream hold).
- `wire_exe_stall` out 1 — combinational; holds PC, IF/ID and ID/EXE.
- `wire_branch_taken` out 1, `wire_branch_target` out 32 — combinational redirect.

To MEM (registered):
- `MEM_rd_src` out 1, `MEM_MemRead` out 1, `MEM_MemWrite` out 1, `MEM_MemtoReg` out 1, `MEM_RegWrite` out 1.
- `MEM_pc_to_reg` out 32, `MEM_ALU_out` out 32, `MEM_rs2_data` out 32.
- `MEM_rd_addr` out 5, `MEM_funct3` out 3.

## Operation
- **ALU ops:**
  - OP/OP-IMM: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - SUB and SRA are selected by `funct7[5]`; for OP-IMM this applies to SRAI only.
  - Shift amount is `[4:0]` of the operand.
- **Other opcodes:**
  - LUI: result = imm.
  - AUIPC: result = pc+imm.
  - LOAD/STORE: result = rs1+imm, with no alignment check.
  - JAL/JALR: `MEM_rd_src`=1, `MEM_pc_to_reg`=pc+4.
- **Branches:**
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - `wire_branch_taken` = `EXE_valid` & condition; target = pc+imm.
  - JAL is always taken, target pc+imm.
  - JALR is always taken, target (rs1+imm) & ~1.
- **Register passing:** `MEM_rs2_data` is the raw rs2; MEM does byte-lane steering. `MEM_funct3` is passed through.
- **Bubbles:** when `EXE_valid`=0, the register captures `MemRead`/`MemWrite`/`RegWrite`=0.
- **M-ops:** opcode 0110011 with funct7 0000001 run through the FSM.
  - IDLE: a valid M-op drives `wire_exe_stall`=1, latches the operands and enters BUSY.
  - BUSY: counter runs 0..31, one step per cycle. MUL* uses shift-add on 64-bit magnitudes; DIV* uses restoring division on magnitudes; signs are fixed up at the end. At count 31 → DONE.
  - DONE: stall=0 and the result is presented. If `EXE_MEM_RegWrite`=1 → IDLE; otherwise stay in DONE with stall=0 and the result held.
  - MULH, MULHSU and MULHU return `[63:32]`; MUL returns `[31:0]`.
- **Divide special cases:**
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - 0x80000000 / −1: quotient = 0x80000000, remainder = 0.
  - Both cases still take the full latency.

## Timing
- **Reset:**
  - All `MEM_*` outputs are 0 after the first `rst` edge.
  - FSM goes to IDLE and the counter to 0.
  - `wire_exe_stall` is 0 from the cycle after reset is sampled.
  - Reset mid-BUSY aborts the operation with no result written.
- **Latency:**
  - Non-M ops are captured into `MEM_*` on the next edge where `EXE_MEM_RegWrite`=1.
  - An M-op issued in cycle 0 holds stall=1 for cycles 0–32. DONE is in cycle 33, and `MEM_*` is updated at the end of cycle 33 if advance=1.
- **Downstream hold:** `EXE_MEM_RegWrite`=0 freezes all `MEM_*` outputs and the FSM in DONE. BUSY counting continues.
- **Stall and bubbles:** while stall=1, the EXE/MEM register captures a bubble on advance edges.
- **Combinational outputs:** branch outputs are purely combinational from the current EXE inputs. They are never asserted for M-ops.

## Configuration
- **`EXE_MULDIV_EN` defined:** the FSM and iterative unit are compiled in, as described above.
- **`EXE_MULDIV_EN` undefined:**
  - No FSM; `wire_exe_stall` is tied to 0.
  - An M-op passes through in one cycle with `MEM_ALU_out`=0 and the other controls unchanged.
  - ALU behaviour is identical.

## Test plan
- **ALU and AUIPC:**
  - ADD rs1=0x7FFFFFFF, rs2=1 → `MEM_ALU_out`=0x80000000 one edge later.
  - SRA rs1=0x80000000, shamt 4 → 0xF8000000.
  - AUIPC pc=0x100, imm=0x2000 → 0x2100.
- **Branch and JALR:**
  - BLT rs1=−1, rs2=0, pc=0x40, imm=−8 → taken=1, target=0x38.
  - BLTU with the same operands → taken=0.
  - JALR rs1=0x101, imm=2 → target=0x102, `MEM_pc_to_reg`=pc+4, `MEM_rd_src`=1.
- **MUL/MULH:**
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0.
  - MULHU with the same operands → 0xFFFFFFFE.
  - Stall high for exactly 33 cycles; result in `MEM_ALU_out` at cycle 34.
- **DIV special cases:**
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 7/0 → 7.
  - DIVU 5/0 → 0xFFFFFFFF.
- **Hold and reset:**
  - `EXE_MEM_RegWrite`=0 for 3 cycles in DONE → result held, stall=0; it is captured on the first advance.
  - `rst` asserted at BUSY count 10 → `MEM_*`=0, stall=0 next cycle, and the next ADD issues normally.
- **Bubble:** `EXE_valid`=0 with `EXE_RegWrite`=1 → `MEM_RegWrite`=0, `MEM_MemWrite`=0.
